zone_spi_tx: RTL and testbench

- Reader side of the zone-average buffer. It accepts the per-zone average bytes produced by the zone statistics stage (one byte per data-enable pulse, AREA_NUM per frame).
- Stores them in a ping-pong buffer and transmits each completed set as one SPI master frame (mode 0, MSB first) to the LED/backlight controller.
- Sits between the zone averaging block and the external SPI pins.

---
 rtl/zone_spi_tx.sv | 175 +++++++++++++++++
 tb/tb_zone_spi_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zone_spi_tx.sv
// Zone-average ping-pong buffer and SPI mode-0 master.
// Each completed set of AREA_NUM bytes goes out as HEADER followed by the zone bytes, MSB first.
module zone_spi_tx #(
    parameter int unsigned AREA_NUM = 24,
    parameter int unsigned CLK_DIV  = 4,
    parameter logic [7:0]  HEADER   = 8'hA5,
    parameter int unsigned GAP_CYC  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_v_sync,
    input  logic [7:0] i_data,
    input  logic       i_data_en,
    output logic       spi_sclk,
    output logic       spi_cs_n,
    output logic       spi_mosi,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic       o_overrun
);
    localparam int unsigned IW   = $clog2(AREA_NUM);
    localparam int unsigned BW   = $clog2(AREA_NUM + 1);
    localparam int unsigned CMAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          phase, phase_nx;
    logic [2:0]    bit_cnt, bit_nx;
    logic [BW-1:0] byte_cnt, byte_nx;

    logic [7:0]    mem [2][AREA_NUM];
    logic [IW-1:0] wr_idx, wr_pos;
    logic          wr_bank, rd_bank, pending, vs_q;
    logic          vs_rise, wr_ok, wr_last, start;
    logic [BW-1:0] rd_sel;
    logic [7:0]    cur_byte;
    logic          cur_bit;

    assign vs_rise = i_v_sync & ~vs_q;
    assign wr_ok   = i_data_en & ~pending;
    assign wr_pos  = vs_rise ? '0 : wr_idx;
    assign wr_last = wr_ok && (wr_pos == IW'(AREA_NUM - 1));
    // A pending set launches straight out of GAP so the link never idles with data waiting.
    assign start   = ((state == IDLE) && (pending || wr_last)) ||
                     ((state == GAP) && (cnt == CW'(GAP_CYC - 1)) && pending);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q    <= 1'b0;
            wr_idx  <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            pending <= 1'b0;
        end else begin
            vs_q <= i_v_sync;
            if (wr_ok)
                wr_idx <= wr_last ? '0 : wr_pos + IW'(1);
            else if (vs_rise)
                wr_idx <= '0;
            if (start) begin
                rd_bank <= wr_bank;
                wr_bank <= ~wr_bank;
                pending <= 1'b0;
            end else if (wr_last) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_bank][wr_pos] <= i_data;
    end

    assign rd_sel   = (byte_cnt == '0) ? '0 : byte_cnt - BW'(1);
    assign cur_byte = (byte_cnt == '0) ? HEADER : mem[rd_bank][rd_sel[IW-1:0]];
    assign cur_bit  = cur_byte[3'd7 - bit_cnt];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        phase_nx = phase;
        bit_nx   = bit_cnt;
        byte_nx  = byte_cnt;
        case (state)
            IDLE: ;
            SETUP: begin
                if (cnt == CW'(CLK_DIV - 1)) begin
                    state_nx = SHIFT;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            SHIFT: begin
                if (cnt == CW'(CLK_DIV - 1)) begin
                    cnt_nx   = '0;
                    phase_nx = ~phase;
                    if (phase) begin
                        if (bit_cnt == 3'd7) begin
                            bit_nx = '0;
                            if (byte_cnt == BW'(AREA_NUM))
                                state_nx = HOLD;
                            else
                                byte_nx = byte_cnt + BW'(1);
                        end else begin
                            bit_nx = bit_cnt + 3'd1;
                        end
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            HOLD: begin
                if (cnt == CW'(CLK_DIV - 1)) begin
                    state_nx = GAP;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            GAP: begin
                if (cnt == CW'(GAP_CYC - 1)) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
        if (start) begin
            state_nx = SETUP;
            cnt_nx   = '0;
            phase_nx = 1'b0;
            bit_nx   = '0;
            byte_nx  = '0;
        end
    end

    // Pin outputs are registered from the current state, so they trail the FSM by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            phase        <= 1'b0;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            spi_sclk     <= 1'b0;
            spi_cs_n     <= 1'b1;
            spi_mosi     <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            phase        <= phase_nx;
            bit_cnt      <= bit_nx;
            byte_cnt     <= byte_nx;
            spi_sclk     <= (state == SHIFT) && phase;
            spi_cs_n     <= !(state inside {SETUP, SHIFT, HOLD});
            if (state == SETUP || state == SHIFT)
                spi_mosi <= cur_bit;
            else if (state != HOLD)
                spi_mosi <= 1'b0;
            o_busy       <= (state != IDLE);
            o_frame_done <= (state == GAP) && (cnt == '0);
            o_overrun    <= i_data_en & pending;
        end
    end
endmodule

// File: tb/tb_zone_spi_tx.sv
// Directed bench for zone_spi_tx: decodes the SPI stream and checks frame content and timing.
// A second CLK_DIV=1 instance on the same inputs is watched for mode-0 setup/hold.
module tb_zone_spi_tx;
    localparam int         AREA = 24;
    localparam logic [7:0] HDR  = 8'hA5;
    localparam int         GAPC = 8;

    logic       clk = 1'b0, rst_n = 1'b0, i_v_sync = 1'b0, i_data_en = 1'b0;
    logic [7:0] i_data = '0;
    logic       spi_sclk, spi_cs_n, spi_mosi, o_busy, o_frame_done, o_overrun;
    logic       b_sclk, b_cs_n, b_mosi, b_busy, b_done, b_ovr;

    always #5 clk = ~clk;

    zone_spi_tx #(.AREA_NUM(AREA), .CLK_DIV(2), .HEADER(HDR), .GAP_CYC(GAPC)) dut (
        .clk(clk), .rst_n(rst_n), .i_v_sync(i_v_sync), .i_data(i_data), .i_data_en(i_data_en),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .o_busy(o_busy), .o_frame_done(o_frame_done), .o_overrun(o_overrun));

    zone_spi_tx #(.AREA_NUM(AREA), .CLK_DIV(1), .HEADER(HDR), .GAP_CYC(GAPC)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_v_sync(i_v_sync), .i_data(i_data), .i_data_en(i_data_en),
        .spi_sclk(b_sclk), .spi_cs_n(b_cs_n), .spi_mosi(b_mosi),
        .o_busy(b_busy), .o_frame_done(b_done), .o_overrun(b_ovr));

    int vec_cnt = 0, bad_cnt = 0;

    // Stream decoder for the CLK_DIV=2 instance.
    int         a_nfr = 0, a_rises = 0, a_low = 0, a_hi = 0, a_done = 0, a_ovr = 0, a_idle_bad = 0;
    logic       a_pcs = 1'b1, a_psclk = 1'b0;
    logic [7:0] a_sh = '0;
    logic [7:0] a_bytes [16][AREA+1];
    int         a_fr_rises [16], a_fr_low [16], a_fr_gap [16];

    always @(negedge clk) begin
        if (!spi_cs_n) begin
            a_low++;
            if (a_pcs) begin
                if (a_nfr < 16) a_fr_gap[a_nfr] = a_hi;
                a_hi = 0;
            end
            if (spi_sclk && !a_psclk) begin
                a_sh = {a_sh[6:0], spi_mosi};
                a_rises++;
                if (a_rises % 8 == 0 && a_rises <= 8*(AREA+1) && a_nfr < 16)
                    a_bytes[a_nfr][a_rises/8-1] = a_sh;
            end
        end else begin
            a_hi++;
            if (spi_sclk) a_idle_bad++;
            if (!a_pcs) begin
                if (a_nfr < 16) begin
                    a_fr_rises[a_nfr] = a_rises;
                    a_fr_low[a_nfr]   = a_low;
                end
                a_nfr++;
                a_rises = 0;
                a_low   = 0;
            end
        end
        if (o_frame_done) a_done++;
        if (o_overrun) a_ovr++;
        a_pcs   = spi_cs_n;
        a_psclk = spi_sclk;
    end

    // Decoder and mode-0 watcher for the CLK_DIV=1 instance.
    int         b_nfr = 0, b_rises = 0, b_low = 0, b_mode_bad = 0, b_idle_bad = 0, b_r0 = -1, b_l0 = -1;
    logic       b_pcs = 1'b1, b_psclk = 1'b0, b_pmosi = 1'b0;
    logic [7:0] b_sh = '0;
    logic [7:0] b_bytes [AREA+1];

    always @(negedge clk) begin
        if (!b_cs_n) begin
            b_low++;
            if (b_sclk && !b_psclk) begin
                if (b_mosi !== b_pmosi) b_mode_bad++;
                b_sh = {b_sh[6:0], b_mosi};
                b_rises++;
                if (b_nfr == 0 && b_rises % 8 == 0 && b_rises <= 8*(AREA+1))
                    b_bytes[b_rises/8-1] = b_sh;
            end
        end else begin
            if (b_sclk) b_idle_bad++;
            if (!b_pcs) begin
                if (b_nfr == 0) begin
                    b_r0 = b_rises;
                    b_l0 = b_low;
                end
                b_nfr++;
                b_rises = 0;
                b_low   = 0;
            end
        end
        b_pcs   = b_cs_n;
        b_psclk = b_sclk;
        b_pmosi = b_mosi;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_frame(input logic [7:0] fr [AREA+1], input logic [7:0] base, input string name);
        int         bad = -1;
        logic [7:0] exp, got = '0, want = '0;
        for (int j = 0; j <= AREA; j++) begin
            exp = (j == 0) ? HDR : base + 8'(j - 1);
            if (fr[j] !== exp && bad < 0) begin
                bad  = j;
                got  = fr[j];
                want = exp;
            end
        end
        vec_cnt++;
        if (bad >= 0) begin
            bad_cnt++;
            $display("FAIL %s: byte %0d got %02h expected %02h", name, bad, got, want);
        end
    endtask

    task automatic put(input logic [7:0] b, input logic vs);
        i_data    = b;
        i_data_en = 1'b1;
        i_v_sync  = vs;
        @(posedge clk); #1;
        i_data_en = 1'b0;
        i_v_sync  = 1'b0;
    endtask

    task automatic put_set(input logic [7:0] base);
        for (int i = 0; i < AREA; i++) put(base + 8'(i), 1'b0);
    endtask

    task automatic wait_frames(input int n, input string name);
        int t = 0;
        while (a_nfr < n && t < 5000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk(name, a_nfr >= n, 1);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (o_busy && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        chk(name, o_busy, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] base;
        int         partial;
        logic       vs_first;
        logic [7:0] exp_first;
        int         exp_rises;
        int         exp_low;
    } vec_t;

    initial begin
        vec_t vt [3];
        int   f0, d0, o0, t;

        vt[0] = '{base: 8'h01, partial: 0,  vs_first: 1'b0, exp_first: 8'h01, exp_rises: 200, exp_low: 804};
        vt[1] = '{base: 8'h40, partial: 10, vs_first: 1'b0, exp_first: 8'h40, exp_rises: 200, exp_low: 804};
        vt[2] = '{base: 8'hC0, partial: 5,  vs_first: 1'b1, exp_first: 8'hC0, exp_rises: 200, exp_low: 804};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", spi_sclk, 0);
        chk("rst_cs_n", spi_cs_n, 1);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_frame_done, 0);
        chk("rst_ovr",  o_overrun, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 3; v++) begin
            f0 = a_nfr; d0 = a_done; o0 = a_ovr;
            for (int i = 0; i < vt[v].partial; i++) put(8'hE0 + 8'(i), 1'b0);
            if (vt[v].partial > 0 && !vt[v].vs_first) begin
                i_v_sync = 1'b1;
                @(posedge clk); #1;
                i_v_sync = 1'b0;
                @(posedge clk); #1;
            end
            for (int i = 0; i < AREA; i++) put(vt[v].base + 8'(i), vt[v].vs_first && i == 0);
            wait_frames(f0 + 1, "vec_frame");
            wait_idle("vec_idle");
            chk_frame(a_bytes[f0], vt[v].exp_first, "vec_data");
            chk("vec_rises", a_fr_rises[f0], vt[v].exp_rises);
            chk("vec_cs_low", a_fr_low[f0], vt[v].exp_low);
            chk("vec_done", a_done - d0, 1);
            chk("vec_ovr", a_ovr - o0, 0);
            chk("vec_nframes", a_nfr - f0, 1);
        end

        // Second set while busy goes pending; a third set while pending is dropped.
        f0 = a_nfr; d0 = a_done; o0 = a_ovr;
        for (int i = 0; i < AREA - 1; i++) put(8'h01 + 8'(i), 1'b0);
        put(8'h18, 1'b0);
        chk("lat_before", spi_cs_n, 1);
        @(posedge clk); #1;
        chk("lat_fall", spi_cs_n, 0);
        repeat (100) @(posedge clk);
        #1;
        put_set(8'h80);
        chk("pend_no_ovr", a_ovr - o0, 0);
        put_set(8'h30);
        wait_frames(f0 + 2, "pend_frames");
        wait_idle("pend_idle");
        chk_frame(a_bytes[f0], 8'h01, "pend_a_data");
        chk_frame(a_bytes[f0+1], 8'h80, "pend_b_data");
        chk("pend_gap", a_fr_gap[f0+1], GAPC);
        chk("pend_b_rises", a_fr_rises[f0+1], 200);
        chk("pend_b_cs_low", a_fr_low[f0+1], 804);
        chk("pend_ovr", a_ovr - o0, 24);
        chk("pend_done", a_done - d0, 2);

        // Reset in the middle of byte 12 of the shift.
        f0 = a_nfr; d0 = a_done;
        put_set(8'h20);
        t = 0;
        while (!(a_nfr == f0 && a_rises >= 97) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        chk("abort_reach", a_rises >= 97, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_cs_n", spi_cs_n, 1);
        chk("abort_sclk", spi_sclk, 0);
        chk("abort_mosi", spi_mosi, 0);
        chk("abort_busy", o_busy, 0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_done", a_done - d0, 0);
        f0 = a_nfr;
        put_set(8'h60);
        wait_frames(f0 + 1, "fresh_frame");
        wait_idle("fresh_idle");
        chk_frame(a_bytes[f0], 8'h60, "fresh_data");
        chk("fresh_rises", a_fr_rises[f0], 200);
        chk("fresh_cs_low", a_fr_low[f0], 804);
        chk("fresh_done", a_done - d0, 1);

        chk("a_sclk_idle", a_idle_bad, 0);
        chk("b_sclk_idle", b_idle_bad, 0);
        chk("b_mode0", b_mode_bad, 0);
        chk("b_rises", b_r0, 200);
        chk("b_cs_low", b_l0, 402);
        chk_frame(b_bytes, 8'h01, "b_data");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, bad_cnt);
        $finish;
    end
endmodule
